// File: rtl/sd_spi_card_model_if.sv
// SD SPI link bundle between the SD master and the card-side responder.
// The master drives clock, select and command data; the card returns MISO
// and reports every accepted command frame plus its ready status.
interface sd_spi_card_model_if;
    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;
    logic        CMD_STB;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG;
    logic        READY;

    modport master (
        output SCLK, CS, MOSI,
        input  MISO, CMD_STB, CMD_IDX, CMD_ARG, READY
    );

    modport slave (
        input  SCLK, CS, MOSI,
        output MISO, CMD_STB, CMD_IDX, CMD_ARG, READY
    );
endinterface

// File: rtl/sd_spi_card_model.sv
// SPI-mode microSD card responder. SCLK/CS/MOSI are oversampled on CLK50,
// the power-up clock run is enforced, 48-bit command frames are parsed and
// R1/R3/R7 answers for the init sequence are shifted out on MISO.
module sd_spi_card_model #(
    parameter int          NCR        = 1,
    parameter int          INIT_TRIES = 3,
    parameter logic [31:0] OCR        = 32'h00FF8000
) (
    input logic                CLK50,
    input logic                RST,
    sd_spi_card_model_if.slave bus
);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_IDLE,
        ST_RECV,
        ST_NCR,
        ST_RESP
    } state_t;

    localparam logic [6:0] FILL_LAST = 7'(NCR * 8 - 1);
    localparam logic [7:0] PU_LAST   = 8'd73;
    localparam logic [7:0] TRIES     = 8'(INIT_TRIES);

    state_t      state;
    logic        sclk_meta, sclk_sync, sclk_prev;
    logic        cs_meta, cs_sync, cs_q;
    logic        mosi_meta, mosi_sync, mosi_q;
    logic        rise_q, fall_q;
    logic [7:0]  pu_cnt;
    logic [6:0]  bit_cnt;
    logic [45:0] shift_reg;
    logic [39:0] resp_sr;
    logic        resp_long;
    logic        idle_flag, app_flag, ready_r;
    logic [7:0]  acmd_cnt;
    logic        miso_r, stb_r;
    logic [5:0]  idx_r;
    logic [31:0] arg_r;

    logic [46:0] rx_bits;
    logic [7:0]  r1;
    logic [39:0] resp_word;
    logic        resp_word_long;
    logic        nxt_idle, nxt_ready;
    logic [7:0]  nxt_cnt;

    assign bus.MISO    = miso_r;
    assign bus.CMD_STB = stb_r;
    assign bus.CMD_IDX = idx_r;
    assign bus.CMD_ARG = arg_r;
    assign bus.READY   = ready_r;

    // Two-flop synchronisers, then edge detect registered so the FSM acts one cycle later.
    always_ff @(posedge CLK50) begin
        if (RST) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_q      <= 1'b1;
            mosi_meta <= 1'b1;
            mosi_sync <= 1'b1;
            mosi_q    <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sclk_meta <= bus.SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= bus.CS;
            cs_sync   <= cs_meta;
            cs_q      <= cs_sync;
            mosi_meta <= bus.MOSI;
            mosi_sync <= mosi_meta;
            mosi_q    <= mosi_sync;
            rise_q    <= sclk_sync & ~sclk_prev;
            fall_q    <= ~sclk_sync & sclk_prev;
        end
    end

    // Decode the frame completing on this rise into its response and the card-state update.
    always_comb begin
        rx_bits        = {shift_reg, mosi_q};
        r1             = {7'b0, idle_flag};
        resp_word      = '0;
        resp_word_long = 1'b0;
        nxt_idle       = idle_flag;
        nxt_ready      = ready_r;
        nxt_cnt        = acmd_cnt;
        case (rx_bits[45:40])
            6'd0: begin
                nxt_idle  = 1'b1;
                nxt_ready = 1'b0;
                nxt_cnt   = 8'd0;
                resp_word = {8'h01, 32'h0};
            end
            6'd8: begin
                resp_word      = {r1, 8'h00, 8'h00, 4'h0, rx_bits[19:16], rx_bits[15:8]};
                resp_word_long = 1'b1;
            end
            6'd55: resp_word = {r1, 32'h0};
            6'd41: begin
                if (!app_flag) begin
                    resp_word = {r1 | 8'h04, 32'h0};
                end else if (acmd_cnt < TRIES) begin
                    nxt_cnt   = acmd_cnt + 8'd1;
                    resp_word = {8'h01, 32'h0};
                end else begin
                    nxt_idle  = 1'b0;
                    nxt_ready = 1'b1;
                    resp_word = {8'h00, 32'h0};
                end
            end
            6'd58: begin
                resp_word      = {r1, ~idle_flag, OCR[30:0]};
                resp_word_long = 1'b1;
            end
            6'd16:   resp_word = {r1, 32'h0};
            default: resp_word = {r1 | 8'h04, 32'h0};
        endcase
    end

    // Card FSM: power-up gate, frame receive, NCR filler, response shift-out.
    always_ff @(posedge CLK50) begin
        if (RST) begin
            state     <= ST_POWERUP;
            pu_cnt    <= 8'd0;
            bit_cnt   <= 7'd0;
            shift_reg <= '0;
            resp_sr   <= '0;
            resp_long <= 1'b0;
            idle_flag <= 1'b1;
            app_flag  <= 1'b0;
            ready_r   <= 1'b0;
            acmd_cnt  <= 8'd0;
            miso_r    <= 1'b1;
            stb_r     <= 1'b0;
            idx_r     <= 6'd0;
            arg_r     <= 32'd0;
        end else begin
            stb_r <= 1'b0;
            if (state != ST_POWERUP && cs_q) begin
                state  <= ST_IDLE;
                miso_r <= 1'b1;
            end else begin
                case (state)
                    ST_POWERUP: begin
                        miso_r <= 1'b1;
                        if (rise_q) begin
                            if (cs_q && mosi_q) begin
                                if (pu_cnt != 8'hFF) pu_cnt <= pu_cnt + 8'd1;
                                if (pu_cnt >= PU_LAST) state <= ST_IDLE;
                            end else begin
                                pu_cnt <= 8'd0;
                            end
                        end
                    end
                    ST_IDLE: begin
                        if (rise_q && !mosi_q) begin
                            shift_reg <= '0;
                            bit_cnt   <= 7'd1;
                            state     <= ST_RECV;
                        end
                    end
                    ST_RECV: begin
                        if (rise_q) begin
                            shift_reg <= rx_bits[45:0];
                            bit_cnt   <= bit_cnt + 7'd1;
                            if (bit_cnt == 7'd1 && !mosi_q) begin
                                state <= ST_IDLE;
                            end else if (bit_cnt == 7'd47) begin
                                if (rx_bits[46] && mosi_q) begin
                                    idx_r     <= rx_bits[45:40];
                                    arg_r     <= rx_bits[39:8];
                                    stb_r     <= 1'b1;
                                    idle_flag <= nxt_idle;
                                    ready_r   <= nxt_ready;
                                    acmd_cnt  <= nxt_cnt;
                                    app_flag  <= (rx_bits[45:40] == 6'd55);
                                    resp_sr   <= resp_word;
                                    resp_long <= resp_word_long;
                                    bit_cnt   <= 7'd0;
                                    state     <= ST_NCR;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                        end
                    end
                    ST_NCR: begin
                        if (fall_q) begin
                            miso_r <= 1'b1;
                            if (bit_cnt == FILL_LAST) begin
                                bit_cnt <= 7'd0;
                                state   <= ST_RESP;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end
                    ST_RESP: begin
                        if (fall_q) begin
                            if (bit_cnt == (resp_long ? 7'd40 : 7'd8)) begin
                                miso_r <= 1'b1;
                                state  <= ST_IDLE;
                            end else begin
                                miso_r  <= resp_sr[39];
                                resp_sr <= {resp_sr[38:0], 1'b0};
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end
                    default: state <= ST_POWERUP;
                endcase
            end
        end
    end

endmodule
